// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD text writer: timing defaults,
// DDRAM line addresses and the state encodings of both FSMs.
package lcd_pkg;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_EHIGH = 12;
    localparam int unsigned DEF_T_GAP   = 50;
    localparam int unsigned DEF_T_CMD   = 2000;

    localparam logic [7:0] LINE1_BASE = 8'h80;
    localparam logic [7:0] LINE2_BASE = 8'hC0;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int unsigned LINE_LEN  = 16;
    localparam int unsigned BUF_DEPTH = 2 * LINE_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2,
        ST_FINISH
    } wr_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP_HI,
        TX_EHIGH_HI,
        TX_GAP,
        TX_SETUP_LO,
        TX_EHIGH_LO,
        TX_SETTLE
    } tx_state_t;

endpackage

// File: rtl/lcd_text_writer_byte_tx.sv
// Sends one byte to a 4-bit HD44780-style bus as two enable-strobed nibbles,
// followed by a command settle interval; tx_done marks the final settle cycle.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_EHIGH = DEF_T_EHIGH,
    parameter int unsigned T_GAP   = DEF_T_GAP,
    parameter int unsigned T_CMD   = DEF_T_CMD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] tx_byte,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] sf_d,
    output logic       tx_done
);

    localparam int unsigned T_MAX_A = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int unsigned T_MAX_B = (T_GAP > T_CMD) ? T_GAP : T_CMD;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] SETUP_END = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] EHIGH_END = TW'(T_EHIGH - 1);
    localparam logic [TW-1:0] GAP_END   = TW'(T_GAP - 1);
    localparam logic [TW-1:0] CMD_END   = TW'(T_CMD - 1);

    tx_state_t     state, state_next;
    logic [TW-1:0] timer, end_val;
    logic          last;
    logic [7:0]    byte_q;
    logic          rs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= TX_IDLE;
            timer  <= '0;
            byte_q <= '0;
            rs_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == TX_IDLE || last) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if (state == TX_IDLE && go) begin
                byte_q <= tx_byte;
                rs_q   <= rs;
            end
        end
    end

    always_comb begin
        end_val = '0;
        case (state)
            TX_SETUP_HI, TX_SETUP_LO: end_val = SETUP_END;
            TX_EHIGH_HI, TX_EHIGH_LO: end_val = EHIGH_END;
            TX_GAP:                   end_val = GAP_END;
            TX_SETTLE:                end_val = CMD_END;
            default:                  end_val = '0;
        endcase
        last = (timer == end_val);
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:     if (go)   state_next = TX_SETUP_HI;
            TX_SETUP_HI: if (last) state_next = TX_EHIGH_HI;
            TX_EHIGH_HI: if (last) state_next = TX_GAP;
            TX_GAP:      if (last) state_next = TX_SETUP_LO;
            TX_SETUP_LO: if (last) state_next = TX_EHIGH_LO;
            TX_EHIGH_LO: if (last) state_next = TX_SETTLE;
            TX_SETTLE:   if (last) state_next = TX_IDLE;
            default:               state_next = TX_IDLE;
        endcase
    end

    // Decoded straight from the async-reset state so rst drops lcd_e at once.
    always_comb begin
        lcd_e   = 1'b0;
        lcd_rs  = 1'b0;
        sf_d    = '0;
        tx_done = 1'b0;
        case (state)
            TX_SETUP_HI, TX_GAP: begin
                lcd_rs = rs_q;
                sf_d   = byte_q[7:4];
            end
            TX_EHIGH_HI: begin
                lcd_e  = 1'b1;
                lcd_rs = rs_q;
                sf_d   = byte_q[7:4];
            end
            TX_SETUP_LO: begin
                lcd_rs = rs_q;
                sf_d   = byte_q[3:0];
            end
            TX_EHIGH_LO: begin
                lcd_e  = 1'b1;
                lcd_rs = rs_q;
                sf_d   = byte_q[3:0];
            end
            TX_SETTLE: begin
                lcd_rs  = rs_q;
                sf_d    = byte_q[3:0];
                tx_done = last;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_text_writer.sv
// Full-screen refresh of a 2x16 character LCD from a 32-byte text buffer:
// line-1 address, 16 chars, line-2 address, 16 chars, then a done pulse.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_EHIGH = DEF_T_EHIGH,
    parameter int unsigned T_GAP   = DEF_T_GAP,
    parameter int unsigned T_CMD   = DEF_T_CMD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       start,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] sf_d
);

    if (CLK_HZ == 0 || T_SETUP == 0 || T_EHIGH == 0 || T_GAP == 0 || T_CMD == 0) begin : g_bad_timing
        $error("lcd_text_writer: clock and timing parameters must be non-zero");
    end

    wr_state_t  state, state_next;
    logic [3:0] idx, idx_next;
    logic       pending, pending_next;
    logic       line_last;
    logic [7:0] char_buf [BUF_DEPTH];

    logic       go;
    logic       tx_rs;
    logic [7:0] tx_byte;
    logic       tx_done;

    assign lcd_rw    = 1'b0;
    assign line_last = (idx == 4'(LINE_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                char_buf[i] <= CHAR_SPACE;
            end
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            pending <= pending_next;
        end
    end

    // pending marks a byte handed to the transmitter and not yet finished.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        pending_next = pending;
        case (state)
            ST_IDLE, ST_FINISH: begin
                state_next = (start && init_done) ? ST_ADDR1 : ST_IDLE;
            end
            default: begin
                if (!pending) begin
                    pending_next = 1'b1;
                end else if (tx_done) begin
                    pending_next = 1'b0;
                    if (!init_done) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        case (state)
                            ST_ADDR1: state_next = ST_LINE1;
                            ST_LINE1: begin
                                if (line_last) begin
                                    idx_next   = '0;
                                    state_next = ST_ADDR2;
                                end else begin
                                    idx_next = idx + 4'd1;
                                end
                            end
                            ST_ADDR2: state_next = ST_LINE2;
                            ST_LINE2: begin
                                if (line_last) begin
                                    idx_next   = '0;
                                    state_next = ST_FINISH;
                                end else begin
                                    idx_next = idx + 4'd1;
                                end
                            end
                            default: state_next = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        tx_rs   = 1'b0;
        tx_byte = '0;
        case (state)
            ST_ADDR1: begin
                busy    = 1'b1;
                tx_byte = LINE1_BASE;
            end
            ST_LINE1: begin
                busy    = 1'b1;
                tx_rs   = 1'b1;
                tx_byte = char_buf[{1'b0, idx}];
            end
            ST_ADDR2: begin
                busy    = 1'b1;
                tx_byte = LINE2_BASE;
            end
            ST_LINE2: begin
                busy    = 1'b1;
                tx_rs   = 1'b1;
                tx_byte = char_buf[{1'b1, idx}];
            end
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
        go = busy && !pending;
    end

    lcd_byte_tx #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_GAP   (T_GAP),
        .T_CMD   (T_CMD)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .rs      (tx_rs),
        .tx_byte (tx_byte),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .sf_d    (sf_d),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer: a cycle-timeline model of the
// byte stream (computed from the byte schedule) plus a shadow text buffer.
module tb_lcd_text_writer;

    localparam int TS = 2;
    localparam int TE = 12;
    localparam int TG = 50;
    localparam int TC = 60;
    localparam int BL = 1 + 2 * TS + 2 * TE + TG + TC;
    localparam int NB = 34;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       start;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] sf_d;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] model_buf [32];
    int         sched_k [$];
    logic [4:0] sched_a [$];
    logic [7:0] sched_d [$];
    int         rand_wr_pct    = 0;
    int         drop_init_at   = -1;
    int         extra_start_at = -1;
    int         abort_at       = -1;

    lcd_text_writer #(
        .T_SETUP (TS),
        .T_EHIGH (TE),
        .T_GAP   (TG),
        .T_CMD   (TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .start     (start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .sf_d      (sf_d)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] byte_for(input int b);
        if (b == 0)   return 8'h80;
        if (b <= 16)  return model_buf[5'(b - 1)];
        if (b == 17)  return 8'hC0;
        return model_buf[5'(b - 2)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    endtask

    task automatic clear_controls();
        sched_k.delete();
        sched_a.delete();
        sched_d.delete();
        rand_wr_pct    = 0;
        drop_init_at   = -1;
        extra_start_at = -1;
        abort_at       = -1;
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_buf[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Walks the expected timeline cycle by cycle from the accepted start edge.
    task automatic run_refresh(input string tag, input int n_bytes, input bit expect_done);
        int         total, b, o;
        int         p1, p2, p3, p4, p5;
        logic [7:0] exp_b;
        logic       exp_rs;
        logic [3:0] got_hi, got_lo, want_nib;
        logic       got_rs_hi, got_rs_lo, want_e;
        bit         chk, bad, idle_bad;
        int         bad_o;
        logic       bad_e, bad_want_e, bad_busy;
        logic [3:0] bad_d;
        total = n_bytes * BL;
        p1 = TS; p2 = p1 + TE; p3 = p2 + TG; p4 = p3 + TS; p5 = p4 + TE;
        exp_b = '0; exp_rs = 1'b0; got_hi = 'x; got_lo = 'x; got_rs_hi = 'x; got_rs_lo = 'x;
        bad = 0; bad_o = 0; bad_e = 0; bad_want_e = 0; bad_busy = 0; bad_d = '0;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (k == total) break;
            b = k / BL;
            o = k % BL;
            if (o == 0) begin
                exp_b = byte_for(b);
                exp_rs = (b != 0 && b != 17);
                got_hi = 'x; got_lo = 'x; got_rs_hi = 'x; got_rs_lo = 'x;
                bad = 0;
            end
            want_e = 1'b0; chk = 0; want_nib = exp_b[7:4];
            if (o >= 1 && o <= p1) chk = 1;
            else if (o > p1 && o <= p2) begin chk = 1; want_e = 1'b1; end
            else if (o > p3 && o <= p4) begin chk = 1; want_nib = exp_b[3:0]; end
            else if (o > p4 && o <= p5) begin chk = 1; want_e = 1'b1; want_nib = exp_b[3:0]; end
            if (!bad && (lcd_e !== want_e || lcd_rw !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
                         (chk && (sf_d !== want_nib || lcd_rs !== exp_rs)))) begin
                bad = 1; bad_o = o; bad_e = lcd_e; bad_want_e = want_e; bad_busy = busy; bad_d = sf_d;
            end
            if (o == p1 + 1) begin got_hi = sf_d; got_rs_hi = lcd_rs; end
            if (o == p4 + 1) begin got_lo = sf_d; got_rs_lo = lcd_rs; end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                tests_run++;
                if (lcd_e !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s async lcd_e: got %b, expected 0 before next clock edge", tag, lcd_e);
                end
                tests_run++;
                if (busy !== 1'b0 || done !== 1'b0 || sf_d !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL %s reset outputs: busy=%b done=%b sf_d=%h, expected 0 0 0", tag, busy, done, sf_d);
                end
                return;
            end
            if (o == BL - 1) begin
                tests_run++;
                if ({got_hi, got_lo} !== exp_b || got_rs_hi !== exp_rs || got_rs_lo !== exp_rs) begin
                    tests_failed++;
                    $display("FAIL %s byte %0d: got %h%h rs=%b/%b, expected %02h rs=%b",
                             tag, b, got_hi, got_lo, got_rs_hi, got_rs_lo, exp_b, exp_rs);
                end
                tests_run++;
                if (bad) begin
                    tests_failed++;
                    $display("FAIL %s timing byte %0d: offset %0d got lcd_e=%b sf_d=%h busy=%b, expected lcd_e=%b busy=1",
                             tag, b, bad_o, bad_e, bad_d, bad_busy, bad_want_e);
                end
            end
            if (k == drop_init_at)   init_done = 1'b0;
            if (k == extra_start_at) start = 1'b1;
            foreach (sched_k[i]) begin
                if (sched_k[i] == k) begin
                    wr_en = 1'b1; wr_addr = sched_a[i]; wr_data = sched_d[i];
                    model_buf[sched_a[i]] = sched_d[i];
                end
            end
            if (!wr_en && rand_wr_pct > 0 && $urandom_range(99) < 32'(rand_wr_pct)) begin
                wr_en = 1'b1; wr_addr = 5'($urandom_range(31)); wr_data = 8'($urandom_range(255));
                model_buf[wr_addr] = wr_data;
            end
        end
        tests_run++;
        if (done !== expect_done || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s end at cycle %0d: done=%b busy=%b, expected done=%b busy=0",
                     tag, total, done, busy, expect_done);
        end
        idle_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || lcd_e !== 1'b0 || sf_d !== 4'h0 || lcd_rw !== 1'b0)
                idle_bad = 1;
        end
        tests_run++;
        if (idle_bad) begin
            tests_failed++;
            $display("FAIL %s idle after: done=%b busy=%b lcd_e=%b sf_d=%h, expected all 0", tag, done, busy, lcd_e, sf_d);
        end
    endtask

    task automatic test_reset();
        bit act;
        #1;
        tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset busy: got %b, expected 0", busy); end
        tests_run++; if (done !== 1'b0)   begin tests_failed++; $display("FAIL reset done: got %b, expected 0", done); end
        tests_run++; if (lcd_e !== 1'b0)  begin tests_failed++; $display("FAIL reset lcd_e: got %b, expected 0", lcd_e); end
        tests_run++; if (lcd_rs !== 1'b0) begin tests_failed++; $display("FAIL reset lcd_rs: got %b, expected 0", lcd_rs); end
        tests_run++; if (sf_d !== 4'h0)   begin tests_failed++; $display("FAIL reset sf_d: got %h, expected 0", sf_d); end
        tests_run++; if (lcd_rw !== 1'b0) begin tests_failed++; $display("FAIL reset lcd_rw: got %b, expected 0", lcd_rw); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        init_done = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (lcd_e !== 1'b0 || busy !== 1'b0) act = 1;
        end
        tests_run++;
        if (act) begin tests_failed++; $display("FAIL reset idle: lcd_e=%b busy=%b, expected 0 0", lcd_e, busy); end
    endtask

    task automatic test_default_refresh();
        clear_controls();
        kick();
        run_refresh("default", NB, 1);
    endtask

    task automatic test_hello_world();
        logic [7:0] hello [5];
        logic [7:0] world [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
        clear_controls();
        for (int a = 0; a < 32; a++) write_char(5'(a), 8'($urandom_range(126, 32)));
        for (int i = 0; i < 5; i++) begin
            write_char(5'(i), hello[i]);
            write_char(5'(16 + i), world[i]);
        end
        kick();
        run_refresh("hello", NB, 1);
    endtask

    task automatic test_start_ignored();
        bit act;
        clear_controls();
        init_done = 1'b0;
        kick();
        act = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (lcd_e !== 1'b0 || busy !== 1'b0 || done !== 1'b0) act = 1;
        end
        tests_run++;
        if (act) begin tests_failed++; $display("FAIL start without init: lcd_e=%b busy=%b done=%b, expected 0 0 0", lcd_e, busy, done); end
        init_done = 1'b1;
        extra_start_at = 3 * BL + 7;
        kick();
        run_refresh("start_busy", NB, 1);
    endtask

    task automatic test_write_during();
        clear_controls();
        write_char(5'd0, 8'h30);
        write_char(5'd31, 8'h20);
        sched_k.push_back(10);  sched_a.push_back(5'd31); sched_d.push_back(8'h41);
        sched_k.push_back(BL);  sched_a.push_back(5'd0);  sched_d.push_back(8'h5A);
        kick();
        run_refresh("wr_during", NB, 1);
        tests_run++;
        if (model_buf[31] !== 8'h41) begin tests_failed++; $display("FAIL shadow buffer 31: got %h, expected 41", model_buf[31]); end
    endtask

    task automatic test_random_writes();
        clear_controls();
        rand_wr_pct = 8;
        kick();
        run_refresh("rand_wr", NB, 1);
    endtask

    task automatic test_init_drop();
        clear_controls();
        drop_init_at = 3 * BL + 20;
        kick();
        run_refresh("init_drop", 4, 0);
        init_done = 1'b1;
    endtask

    task automatic test_reset_mid_byte();
        clear_controls();
        abort_at = 5 * BL + TS + 3;
        kick();
        run_refresh("rst_mid", NB, 1);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_controls();
        kick();
        run_refresh("restart", NB, 1);
    endtask

    initial begin
        rst = 1'b1; init_done = 1'b0; start = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        test_reset();
        test_default_refresh();
        test_hello_world();
        test_start_ignored();
        test_write_during();
        test_random_writes();
        test_init_drop();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
